// File: rtl/z80_pkg.sv
// rtl/z80_pkg.sv - shared types for the z80 bus cycle sequencer
package z80_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    MEM_RD = 3'd1,
    MEM_WR = 3'd2,
    IO_RD  = 3'd3,
    IO_WR  = 3'd4
  } bus_cycle_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    TWA  = 3'd3,
    TW   = 3'd4,
    T3   = 3'd5,
    T4   = 3'd6
  } tstate_t;

  // Pin strobes plus internal decode flags (use_rfsh selects the refresh
  // address, last marks the final T-state of a cycle).
  typedef struct packed {
    logic m1_l;
    logic mreq_l;
    logic iorq_l;
    logic rd_l;
    logic wr_l;
    logic rfsh_l;
    logic addr_drive;
    logic data_drive;
    logic use_rfsh;
    logic last;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '{
    m1_l: 1'b1, mreq_l: 1'b1, iorq_l: 1'b1, rd_l: 1'b1, wr_l: 1'b1,
    rfsh_l: 1'b1, addr_drive: 1'b0, data_drive: 1'b0, use_rfsh: 1'b0,
    last: 1'b0
  };

  function automatic logic is_valid_cycle(input logic [2:0] t);
    return t <= 3'd4;
  endfunction

  function automatic logic is_read(input bus_cycle_t c);
    return (c == FETCH) || (c == MEM_RD) || (c == IO_RD);
  endfunction

  function automatic logic is_io(input bus_cycle_t c);
    return (c == IO_RD) || (c == IO_WR);
  endfunction

endpackage

// File: rtl/z80_bus_strobe_decode.sv
// rtl/z80_bus_strobe_decode.sv - combinational (tstate, cycle) to strobe decode
module z80_bus_strobe_decode
  import z80_pkg::*;
(
  input  tstate_t    tstate,
  input  bus_cycle_t cycle,
  output strobe_t    strobes
);

  // Moore decode: every strobe is a pure function of T-state and cycle type
  always_comb begin
    strobes = STROBE_IDLE;
    strobes.addr_drive = (tstate != IDLE);
    case (cycle)
      FETCH: begin
        case (tstate)
          T1, T2, TW: begin
            strobes.m1_l   = 1'b0;
            strobes.mreq_l = 1'b0;
            strobes.rd_l   = 1'b0;
          end
          T3: begin
            strobes.mreq_l   = 1'b0;
            strobes.rfsh_l   = 1'b0;
            strobes.use_rfsh = 1'b1;
          end
          T4: begin
            strobes.rfsh_l   = 1'b0;
            strobes.use_rfsh = 1'b1;
            strobes.last     = 1'b1;
          end
          default: ;
        endcase
      end
      MEM_RD: begin
        case (tstate)
          T1, T2, TW: begin
            strobes.mreq_l = 1'b0;
            strobes.rd_l   = 1'b0;
          end
          T3: strobes.last = 1'b1;
          default: ;
        endcase
      end
      MEM_WR: begin
        case (tstate)
          T1: begin
            strobes.mreq_l     = 1'b0;
            strobes.data_drive = 1'b1;
          end
          T2, TW: begin
            strobes.mreq_l     = 1'b0;
            strobes.wr_l       = 1'b0;
            strobes.data_drive = 1'b1;
          end
          T3: begin
            strobes.data_drive = 1'b1;
            strobes.last       = 1'b1;
          end
          default: ;
        endcase
      end
      IO_RD, IO_WR: begin
        case (tstate)
          T1: strobes.data_drive = (cycle == IO_WR);
          T2, TWA, TW: begin
            strobes.iorq_l     = 1'b0;
            strobes.rd_l       = (cycle != IO_RD);
            strobes.wr_l       = (cycle != IO_WR);
            strobes.data_drive = (cycle == IO_WR);
          end
          T3: begin
            strobes.data_drive = (cycle == IO_WR);
            strobes.last       = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/z80_bus_cycle_ctrl.sv
// rtl/z80_bus_cycle_ctrl.sv - z80 machine-cycle sequencer (FSM, auto-wait, request/rdata regs)
module z80_bus_cycle_ctrl
  import z80_pkg::*;
#(
  parameter int IO_AUTO_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic [15:0] rfsh_addr,
  output logic        done,
  output logic [7:0]  rdata,
  input  logic [7:0]  data_in,
  input  logic        WAIT_L,
  output logic [15:0] addr_out,
  output logic        addr_drive,
  output logic [7:0]  data_out,
  output logic        data_drive,
  output logic        M1_L,
  output logic        MREQ_L,
  output logic        IORQ_L,
  output logic        RD_L,
  output logic        WR_L,
  output logic        RFSH_L
);

  localparam logic       HAS_TWA  = (IO_AUTO_WAIT > 0);
  localparam logic [1:0] TWA_INIT = 2'((IO_AUTO_WAIT > 0) ? IO_AUTO_WAIT - 1 : 0);

  tstate_t     state;
  bus_cycle_t  cycle_q;
  logic [15:0] addr_q;
  logic [15:0] addr_hold;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic [1:0]  twa_cnt;
  strobe_t     strb;
  logic        start_ok;
  logic        sample_now;
  logic [15:0] cur_addr;

  z80_bus_strobe_decode u_decode (
    .tstate  (state),
    .cycle   (cycle_q),
    .strobes (strb)
  );

  assign req_ready = (state == IDLE) || strb.last;
  // Reserved types are consumed by the handshake but never start a cycle
  assign start_ok  = req_valid && req_ready && is_valid_cycle(req_type);
  // WAIT_L is honoured on the edge leaving T2 (mem) or the last auto-wait (IO)
  assign sample_now = (state == TW)
                   || (state == T2 && !(is_io(cycle_q) && HAS_TWA))
                   || (state == TWA && twa_cnt == 2'd0);

  assign cur_addr   = strb.use_rfsh ? rfsh_addr : addr_q;
  assign addr_out   = strb.addr_drive ? cur_addr : addr_hold;
  assign addr_drive = strb.addr_drive;
  assign data_out   = wdata_q;
  assign data_drive = strb.data_drive;
  assign done       = strb.last;
  assign rdata      = rdata_q;
  assign M1_L       = strb.m1_l;
  assign MREQ_L     = strb.mreq_l;
  assign IORQ_L     = strb.iorq_l;
  assign RD_L       = strb.rd_l;
  assign WR_L       = strb.wr_l;
  assign RFSH_L     = strb.rfsh_l;

  // T-state sequencer with request capture, auto-wait count and read latch
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state     <= IDLE;
      cycle_q   <= FETCH;
      addr_q    <= 16'h0000;
      addr_hold <= 16'h0000;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      twa_cnt   <= 2'd0;
    end else begin
      if (state != IDLE) addr_hold <= cur_addr;
      if (start_ok) begin
        cycle_q <= bus_cycle_t'(req_type);
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (sample_now && WAIT_L && is_read(cycle_q)) rdata_q <= data_in;
      case (state)
        IDLE: if (start_ok) state <= T1;
        T1:   state <= T2;
        T2: begin
          if (is_io(cycle_q) && HAS_TWA) begin
            state   <= TWA;
            twa_cnt <= TWA_INIT;
          end else begin
            state <= WAIT_L ? T3 : TW;
          end
        end
        TWA: begin
          if (twa_cnt == 2'd0) state <= WAIT_L ? T3 : TW;
          else twa_cnt <= twa_cnt - 2'd1;
        end
        TW:   if (WAIT_L) state <= T3;
        T3: begin
          if (cycle_q == FETCH) state <= T4;
          else state <= start_ok ? T1 : IDLE;
        end
        T4:      state <= start_ok ? T1 : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_cycle_ctrl.sv
// tb/tb_z80_bus_cycle_ctrl.sv - self-checking bench for z80_bus_cycle_ctrl
module tb_z80_bus_cycle_ctrl;

  localparam int IO_AUTO_WAIT = 1;

  logic        clk = 1'b0;
  logic        rst_L = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_type = 3'd0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic [15:0] rfsh_addr = 16'h0000;
  logic        done;
  logic [7:0]  rdata;
  logic [7:0]  data_in = 8'h00;
  logic        WAIT_L = 1'b1;
  logic [15:0] addr_out;
  logic        addr_drive;
  logic [7:0]  data_out;
  logic        data_drive;
  logic        M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L;

  always #5 clk = ~clk;

  z80_bus_cycle_ctrl #(.IO_AUTO_WAIT(IO_AUTO_WAIT)) dut (
    .clk(clk), .rst_L(rst_L), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .rfsh_addr(rfsh_addr), .done(done), .rdata(rdata), .data_in(data_in),
    .WAIT_L(WAIT_L), .addr_out(addr_out), .addr_drive(addr_drive),
    .data_out(data_out), .data_drive(data_drive), .M1_L(M1_L), .MREQ_L(MREQ_L),
    .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L), .RFSH_L(RFSH_L)
  );

  typedef struct {
    logic [2:0]  typ;
    logic [15:0] addr;
    logic [15:0] rfsh;
    logic [7:0]  wdata;
    logic [7:0]  din;
    int          waits;
    int          done_cyc;
    int          n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh, n_dd;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vt[6];
  vec_t sb[$];
  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int c_m1, c_mreq, c_iorq, c_rd, c_wr, c_rfsh, c_dd, ws;
    bit got_done;
    vec_t e;
    c_m1 = 0; c_mreq = 0; c_iorq = 0; c_rd = 0; c_wr = 0; c_rfsh = 0; c_dd = 0;
    got_done = 0;
    ws = (v.typ == 3'd3 || v.typ == 3'd4) ? 2 + IO_AUTO_WAIT : 2;
    @(negedge clk);
    req_valid = 1'b1; req_type = v.typ; req_addr = v.addr; req_wdata = v.wdata;
    rfsh_addr = v.rfsh; data_in = v.din; WAIT_L = 1'b1;
    chk("ready_before_req", 32'(req_ready), 32'd1);
    sb.push_back(v);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = ~v.addr; req_wdata = ~v.wdata;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!M1_L) c_m1++;
      if (!MREQ_L) c_mreq++;
      if (!IORQ_L) c_iorq++;
      if (!RD_L) c_rd++;
      if (!WR_L) c_wr++;
      if (!RFSH_L) c_rfsh++;
      if (data_drive) c_dd++;
      chk("rd_wr_overlap", 32'(!RD_L && !WR_L), 32'd0);
      chk("mreq_iorq_overlap", 32'(!MREQ_L && !IORQ_L), 32'd0);
      chk("addr_drive_busy", 32'(addr_drive), 32'd1);
      if (k == 1) chk("addr_t1", 32'(addr_out), 32'(v.addr));
      WAIT_L = !(k >= ws && k < ws + v.waits);
      if (done) begin
        got_done = 1;
        e = sb.pop_front();
        chk("done_cycle", k, e.done_cyc);
        chk("rdata", 32'(rdata), 32'(e.rdata));
        chk("cnt_m1", c_m1, e.n_m1);
        chk("cnt_mreq", c_mreq, e.n_mreq);
        chk("cnt_iorq", c_iorq, e.n_iorq);
        chk("cnt_rd", c_rd, e.n_rd);
        chk("cnt_wr", c_wr, e.n_wr);
        chk("cnt_rfsh", c_rfsh, e.n_rfsh);
        chk("cnt_data_drive", c_dd, e.n_dd);
        if (e.typ == 3'd0) chk("addr_rfsh", 32'(addr_out), 32'(e.rfsh));
        if (e.typ == 3'd2 || e.typ == 3'd4) chk("data_out", 32'(data_out), 32'(e.wdata));
        break;
      end
    end
    if (!got_done) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: no done within 20 cycles for type %0d", v.typ);
      void'(sb.pop_front());
    end
    WAIT_L = 1'b1;
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after", 32'(addr_drive), 32'd0);
  endtask

  initial begin
    int n_done;
    logic quiet;
    vt[0] = '{3'd0, 16'h0000, 16'h3F05, 8'h00, 8'hC3, 0, 4, 2, 3, 0, 2, 0, 2, 0, 8'hC3};
    vt[1] = '{3'd2, 16'h8000, 16'h0000, 8'h5A, 8'hEE, 2, 5, 0, 4, 0, 0, 3, 0, 5, 8'hC3};
    vt[2] = '{3'd3, 16'h00FE, 16'h0000, 8'h00, 8'h1F, 0, 4, 0, 0, 2, 2, 0, 0, 0, 8'h1F};
    vt[3] = '{3'd1, 16'h4000, 16'h0000, 8'h00, 8'hA5, 1, 4, 0, 3, 0, 3, 0, 0, 0, 8'hA5};
    vt[4] = '{3'd4, 16'h0012, 16'h0000, 8'h77, 8'h99, 2, 6, 0, 0, 4, 0, 4, 0, 6, 8'hA5};
    vt[5] = '{3'd0, 16'h1000, 16'h0102, 8'h00, 8'h00, 1, 5, 3, 4, 0, 3, 0, 2, 0, 8'h00};

    // Reset state
    #12;
    chk("rst_strobes", 32'({M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L}), 32'h3F);
    chk("rst_drives", 32'({addr_drive, data_drive}), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_addr_out", 32'(addr_out), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_L = 1'b1;

    foreach (vt[i]) run_vec(vt[i]);

    // Back-to-back MEM_RD with valid held
    n_done = 0;
    @(negedge clk);
    req_valid = 1'b1; req_type = 3'd1; req_addr = 16'h1234; data_in = 8'h11;
    @(posedge clk);
    #1 req_addr = 16'h1235;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (done) n_done++;
      case (k)
        1: chk("b2b_addr1", 32'(addr_out), 32'h1234);
        3: begin
          chk("b2b_done1", 32'(done), 32'd1);
          chk("b2b_rdata1", 32'(rdata), 32'h11);
          chk("b2b_ready_t3", 32'(req_ready), 32'd1);
          data_in = 8'h22;
        end
        4: begin
          req_valid = 1'b0;
          chk("b2b_addr2", 32'(addr_out), 32'h1235);
          chk("b2b_t1_mreq", 32'(MREQ_L), 32'd0);
        end
        6: begin
          chk("b2b_done2", 32'(done), 32'd1);
          chk("b2b_rdata2", 32'(rdata), 32'h22);
        end
        7: chk("b2b_idle", 32'({addr_drive, req_ready}), 32'b01);
        default: ;
      endcase
    end
    chk("b2b_done_count", n_done, 2);

    // Reserved type: accepted, quiet, then a normal FETCH
    @(negedge clk);
    req_valid = 1'b1; req_type = 3'd6; req_addr = 16'hABCD;
    chk("rsv_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (!(M1_L && MREQ_L && IORQ_L && RD_L && WR_L && RFSH_L) || done || addr_drive)
        quiet = 1'b0;
    end
    chk("rsv_quiet", 32'(quiet), 32'd1);
    chk("rsv_ready_after", 32'(req_ready), 32'd1);
    run_vec('{3'd0, 16'h2222, 16'h0A0B, 8'h00, 8'h3E, 0, 4, 2, 3, 0, 2, 0, 2, 0, 8'h3E});

    // Reset during TW of MEM_WR
    @(negedge clk);
    req_valid = 1'b1; req_type = 3'd2; req_addr = 16'h8000; req_wdata = 8'h5A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    WAIT_L = 1'b0;
    @(negedge clk);
    chk("rst_mid_wr_low", 32'(WR_L), 32'd0);
    #2 rst_L = 1'b0;
    #1;
    chk("rst_mid_strobes", 32'({M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L}), 32'h3F);
    chk("rst_mid_drives", 32'({addr_drive, data_drive}), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_rdata", 32'(rdata), 32'd0);
    chk("rst_mid_addr_out", 32'(addr_out), 32'd0);
    @(negedge clk);
    rst_L = 1'b1; WAIT_L = 1'b1;
    n_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("rst_mid_no_done", n_done, 0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_idle_mreq", 32'(MREQ_L), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
